// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - handshaked RV integer ALU plus iterative multiply/divide unit
//
// Purpose: execute-stage unit. Base ALU ops finish in one cycle; M-extension ops
// iterate one bit per cycle (shift-add multiply, restoring divide) on magnitudes,
// with the sign fixed up when the result is registered.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        request handshake
//   instruction                funct3 = [14:12], funct7 = [31:25]
//   in1, in2                   operands (sampled only on the accept edge)
//   kill                       synchronous abort of any in-flight or held op
//   out_valid / out_ready      result handshake; out held while stalled
//   out                        result
//   busy                       high while iterating (MUL or DIV state)
module alu_mdu_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] acc;    // product high half / partial remainder
    logic [XLEN-1:0] lo;     // multiplier being consumed / dividend becoming quotient
    logic [XLEN-1:0] opnd;   // multiplicand magnitude / divisor magnitude
    logic [2:0]      op;
    logic            neg;

    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_m, alt, accept;
    logic [SHW-1:0] shamt;
    logic       unused_bits;

    assign f3          = instruction[14:12];
    assign f7          = instruction[31:25];
    assign is_m        = (f7 == 7'b0000001);
    assign alt         = (f7 == 7'b0100000);
    assign shamt       = in2[SHW-1:0];
    assign unused_bits = &{1'b0, instruction[24:15], instruction[11:0]};

    assign in_ready = !kill && ((state == IDLE) || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign busy     = (state == MUL) || (state == DIV);

    // Base ALU result
    logic [XLEN-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (f3)
            3'd0: alu_res = alt ? in1 - in2 : in1 + in2;
            3'd1: alu_res = in1 << shamt;
            3'd2: alu_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            3'd3: alu_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
            3'd4: alu_res = in1 ^ in2;
            3'd5: alu_res = alt ? XLEN'($signed(in1) >>> shamt) : in1 >> shamt;
            3'd6: alu_res = in1 | in2;
            default: alu_res = in1 & in2;
        endcase
    end

    // Operand signedness, magnitudes and result sign for M ops
    logic            s1, s2, n1, n2, start_neg, div_special;
    logic [XLEN-1:0] mag1, mag2, special_res;
    always_comb begin
        if (f3[2]) begin
            s1 = !f3[0];
            s2 = !f3[0];
        end else begin
            s1 = (f3 == 3'd1) || (f3 == 3'd2);
            s2 = (f3 == 3'd1);
        end
        n1 = s1 && in1[XLEN-1];
        n2 = s2 && in2[XLEN-1];
        mag1 = n1 ? -in1 : in1;
        mag2 = n2 ? -in2 : in2;
        // Remainder takes the dividend's sign; everything else the product of signs
        start_neg = (f3[2] && f3[1]) ? n1 : (n1 ^ n2);
        // Divide by zero and signed overflow are resolved without iterating
        div_special = 1'b0;
        special_res = '0;
        if (f3[2]) begin
            if (in2 == '0) begin
                div_special = 1'b1;
                special_res = f3[1] ? in1 : '1;
            end else if (!f3[0] && in1 == {1'b1, {(XLEN-1){1'b0}}} && in2 == '1) begin
                div_special = 1'b1;
                special_res = f3[1] ? '0 : in1;
            end
        end
    end

    // One shift-add multiply step on the {acc, lo} product register
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_acc, mul_lo;
    always_comb begin
        mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
        mul_acc = mul_sum[XLEN:1];
        mul_lo  = {mul_sum[0], lo[XLEN-1:1]};
    end

    // One restoring-divide step: shift next dividend bit into the remainder
    logic [XLEN:0]   div_shift, div_diff;
    logic [XLEN-1:0] div_acc, div_lo;
    always_comb begin
        div_shift = {acc, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[XLEN]) begin
            div_acc = div_diff[XLEN-1:0];
            div_lo  = {lo[XLEN-2:0], 1'b1};
        end else begin
            div_acc = div_shift[XLEN-1:0];
            div_lo  = {lo[XLEN-2:0], 1'b0};
        end
    end

    // Final results are taken from the values produced by the last step
    logic [2*XLEN-1:0] mul_fix;
    logic [XLEN-1:0]   mul_res, div_raw, div_res;
    always_comb begin
        mul_fix = neg ? -{mul_acc, mul_lo} : {mul_acc, mul_lo};
        mul_res = (op[1:0] == 2'd0) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
        div_raw = op[1] ? div_acc : div_lo;
        div_res = neg ? -div_raw : div_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            cnt       <= '0;
            acc       <= '0;
            lo        <= '0;
            opnd      <= '0;
            op        <= '0;
            neg       <= 1'b0;
        end else if (kill) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                MUL: begin
                    acc <= mul_acc;
                    lo  <= mul_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out       <= mul_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DIV: begin
                    acc <= div_acc;
                    lo  <= div_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out       <= div_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
            // A new request overrides the drain transition taken above
            if (accept) begin
                if (!is_m) begin
                    out       <= alu_res;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else if (div_special) begin
                    out       <= special_res;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    state     <= f3[2] ? DIV : MUL;
                    out_valid <= 1'b0;
                    cnt       <= '0;
                    acc       <= '0;
                    lo        <= f3[2] ? mag1 : mag2;
                    opnd      <= f3[2] ? mag2 : mag1;
                    op        <= f3;
                    neg       <= start_neg;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb/tb_alu_mdu_seq.sv - scoreboard bench for alu_mdu_seq at XLEN 64 and 32
module tb_alu_mdu_seq;
    localparam logic [6:0] M7 = 7'b0000001;
    localparam logic [6:0] A7 = 7'b0100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = '0;
    logic [63:0] in1 = '0, in2 = '0;
    logic        kill = 1'b0, out_ready = 1'b1;
    logic        iv64 = 1'b0, iv32 = 1'b0;
    logic        ir64, ir32, ov64, ov32, busy64, busy32;
    logic [63:0] o64;
    logic [31:0] o32;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    bit   hold0 = 1'b0, hold1 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_mdu_seq #(.XLEN(64)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .instruction(instruction), .in1(in1), .in2(in2), .kill(kill),
        .out_valid(ov64), .out_ready(out_ready), .out(o64), .busy(busy64)
    );

    alu_mdu_seq #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .instruction(instruction), .in1(in1[31:0]), .in2(in2[31:0]), .kill(kill),
        .out_valid(ov32), .out_ready(out_ready), .out(o32), .busy(busy32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input int xl, input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [63:0] ai, input logic [63:0] bi);
        logic [63:0] mask, a, b, r;
        logic [127:0] ua, ub, p;
        logic signed [127:0] sa, sbv, sp;
        int sh;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a  = ai & mask;
        b  = bi & mask;
        ua = {64'd0, a};
        ub = {64'd0, b};
        sa  = (xl == 64) ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
        sbv = (xl == 64) ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
        sh = int'(b[31:0]) & (xl - 1);
        r  = '0;
        if (f7 == M7) begin
            case (f3)
                3'd0: begin p = ua * ub; r = p[63:0]; end
                3'd1: begin sp = sa * sbv; p = 128'(sp) >> xl; r = p[63:0]; end
                3'd2: begin sp = sa * $signed(ub); p = 128'(sp) >> xl; r = p[63:0]; end
                3'd3: begin p = (ua * ub) >> xl; r = p[63:0]; end
                3'd4: if (b == 0) r = mask; else begin sp = sa / sbv; r = sp[63:0]; end
                3'd5: if (b == 0) r = mask; else begin p = ua / ub; r = p[63:0]; end
                3'd6: if (b == 0) r = a; else begin sp = sa % sbv; r = sp[63:0]; end
                default: if (b == 0) r = a; else begin p = ua % ub; r = p[63:0]; end
            endcase
        end else begin
            case (f3)
                3'd0: r = (f7 == A7) ? a - b : a + b;
                3'd1: r = a << sh;
                3'd2: r = (sa < sbv) ? 64'd1 : 64'd0;
                3'd3: r = (a < b) ? 64'd1 : 64'd0;
                3'd4: r = a ^ b;
                3'd5: if (f7 == A7) begin sp = sa >>> sh; r = sp[63:0]; end else r = a >> sh;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return r & mask;
    endfunction

    function automatic int lat_of(input int xl, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [63:0] ai, input logic [63:0] bi);
        logic [63:0] mask, a, b, mn;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        mn   = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        a = ai & mask;
        b = bi & mask;
        if (f7 != M7) return 1;
        if (!f3[2]) return xl + 1;
        if (b == 0) return 1;
        if (!f3[0] && a == mn && b == mask) return 1;
        return xl + 1;
    endfunction

    // Drive one request (entered just after a rising edge) and wait for its accept.
    task automatic issue(input int sel, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] a, input logic [63:0] b, input bit push);
        exp_t e;
        bit   done;
        int   xl;
        xl = (sel != 0) ? 32 : 64;
        e.data = model(xl, f3, f7, a, b);
        e.lat  = lat_of(xl, f3, f7, a, b);
        instruction = {f7, 10'h2A5, f3, 12'h0B3};
        in1 = a;
        in2 = b;
        if (sel != 0) iv32 = 1'b1; else iv64 = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if ((sel != 0) ? ir32 : ir64) begin
                e.acc = cyc;
                if (push) begin
                    if (sel != 0) sb1.push_back(e); else sb0.push_back(e);
                end
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        iv64 = 1'b0;
        iv32 = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 500 && (sb0.size() != 0 || sb1.size() != 0); t++) @(negedge clk);
        if (sb0.size() != 0 || sb1.size() != 0) check("drain_timeout", 64'(sb0.size() + sb1.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input int i);
        logic        v;
        logic [63:0] d;
        exp_t        e;
        v = (i != 0) ? ov32 : ov64;
        d = (i != 0) ? {32'd0, o32} : o64;
        if (!v) return;
        if (((i != 0) ? sb1.size() : sb0.size()) == 0) begin
            check($sformatf("unexpected_out%0d", i), {63'd0, v}, 64'd0);
            return;
        end
        e = (i != 0) ? sb1[0] : sb0[0];
        if (!((i != 0) ? hold1 : hold0))
            check($sformatf("latency%0d", i), 64'(cyc - e.acc), 64'(e.lat));
        check($sformatf("out%0d", i), d, e.data);
        if (out_ready) begin
            if (i != 0) begin void'(sb1.pop_front()); hold1 = 1'b0; end
            else begin void'(sb0.pop_front()); hold0 = 1'b0; end
        end else begin
            if (i != 0) hold1 = 1'b1; else hold0 = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        logic [63:0] mn;
        bit          seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid64", {63'd0, ov64}, 64'd0);
        check("rst_out64", o64, 64'd0);
        check("rst_busy64", {63'd0, busy64}, 64'd0);
        check("rst_out_valid32", {63'd0, ov32}, 64'd0);
        check("rst_out32", {32'd0, o32}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready64", {63'd0, ir64}, 64'd1);
        check("rel_in_ready32", {63'd0, ir32}, 64'd1);
        @(posedge clk);
        #1;

        // Base ALU ops, back to back
        issue(0, 3'd0, 7'd0, 64'd5, 64'd7, 1);
        issue(0, 3'd0, A7, 64'd5, 64'd7, 1);
        issue(0, 3'd5, A7, 64'h8000_0000_0000_0000, 64'd4, 1);
        issue(0, 3'd3, 7'd0, 64'd1, -64'd1, 1);
        issue(0, 3'd1, 7'd0, 64'h0000_0000_0000_00F1, 64'h0000_0000_0000_01C3, 1);
        issue(0, 3'd5, 7'd0, 64'h8000_0000_0000_0000, 64'd68, 1);
        issue(0, 3'd2, 7'd0, -64'd5, 64'd3, 1);
        issue(0, 3'd2, 7'd0, 64'd3, -64'd5, 1);
        issue(0, 3'd0, 7'h11, 64'd100, 64'd23, 1);
        issue(0, 3'd7, A7, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 1);
        for (int k = 0; k < 6; k++)
            issue(0, 3'($urandom_range(7, 0)), (k % 2 == 0) ? 7'd0 : A7,
                  {$urandom, $urandom}, {$urandom, $urandom}, 1);

        // M ops at both widths
        for (int s = 0; s < 2; s++) begin
            mn = (s != 0) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
            issue(s, 3'd3, M7, '1, '1, 1);
            issue(s, 3'd1, M7, '1, '1, 1);
            issue(s, 3'd0, M7, 64'd123456789, 64'd987654321, 1);
            issue(s, 3'd2, M7, -64'd3, 64'hFFFF_FFFF_FFFF_FFF0, 1);
            issue(s, 3'd4, M7, -64'd7, 64'd2, 1);
            issue(s, 3'd6, M7, -64'd7, 64'd2, 1);
            issue(s, 3'd5, M7, 64'd100, 64'd7, 1);
            issue(s, 3'd7, M7, 64'd100, 64'd7, 1);
            issue(s, 3'd4, M7, 64'h1234_5678_9ABC_DEF0, 64'd0, 1);
            issue(s, 3'd6, M7, 64'h1234_5678_9ABC_DEF0, 64'd0, 1);
            issue(s, 3'd5, M7, 64'd42, 64'd0, 1);
            issue(s, 3'd4, M7, mn, '1, 1);
            issue(s, 3'd6, M7, mn, '1, 1);
            issue(s, 3'd5, M7, mn, '1, 1);
            for (int k = 0; k < 4; k++)
                issue(s, 3'($urandom_range(7, 0)), M7, {$urandom, $urandom},
                      {32'd0, $urandom_range(1000, 1)}, 1);
        end
        wait_drain();

        // Output stall: held result, in_ready low, then drain plus accept on one edge
        out_ready = 1'b0;
        issue(0, 3'd0, 7'd0, 64'd40, 64'd2, 1);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = ov64;
        end
        check("stall_out_valid", {63'd0, seen}, 64'd1);
        repeat (10) begin
            @(negedge clk);
            check("stall_in_ready", {63'd0, ir64}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        begin
            exp_t e;
            instruction = {7'd0, 10'h000, 3'd4, 12'h033};
            in1 = 64'h00FF_00FF_00FF_00FF;
            in2 = 64'h0F0F_0F0F_0F0F_0F0F;
            iv64 = 1'b1;
            @(negedge clk);
            check("b2b_in_ready", {63'd0, ir64}, 64'd1);
            e.data = model(64, 3'd4, 7'd0, in1, in2);
            e.lat  = 1;
            e.acc  = cyc;
            sb0.push_back(e);
            @(posedge clk);
            #1 iv64 = 1'b0;
        end
        wait_drain();

        // Kill during a multiply, then kill alongside a request while idle
        issue(0, 3'd0, M7, 64'd99, 64'd77, 0);
        repeat (29) @(posedge clk);
        @(negedge clk);
        check("kill_busy_before", {63'd0, busy64}, 64'd1);
        @(posedge clk);
        #1;
        kill = 1'b1;
        iv64 = 1'b1;
        @(negedge clk);
        check("kill_in_ready", {63'd0, ir64}, 64'd0);
        @(posedge clk);
        #1;
        kill = 1'b0;
        iv64 = 1'b0;
        @(negedge clk);
        check("kill_busy_after", {63'd0, busy64}, 64'd0);
        check("kill_out_valid", {63'd0, ov64}, 64'd0);
        check("kill_idle_ready", {63'd0, ir64}, 64'd1);
        @(posedge clk);
        #1;
        instruction = {7'd0, 10'h000, 3'd0, 12'h033};
        kill = 1'b1;
        iv64 = 1'b1;
        @(negedge clk);
        check("kill_idle_in_ready", {63'd0, ir64}, 64'd0);
        @(posedge clk);
        #1;
        kill = 1'b0;
        iv64 = 1'b0;
        repeat (80) @(negedge clk);
        check("kill_no_result", {63'd0, ov64}, 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide
        issue(0, 3'd4, M7, 64'd1000, 64'd7, 0);
        issue(1, 3'd5, M7, 64'd1000, 64'd7, 0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", {63'd0, ov64}, 64'd0);
        check("rst_mid_busy64", {63'd0, busy64}, 64'd0);
        check("rst_mid_busy32", {63'd0, busy32}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_in_ready64", {63'd0, ir64}, 64'd1);
        check("rst_rel_in_ready32", {63'd0, ir32}, 64'd1);
        repeat (80) @(negedge clk);
        check("rst_no_result", {63'd0, ov64 | ov32}, 64'd0);
        @(posedge clk);
        #1;

        // Recovery after the aborts
        issue(0, 3'd5, M7, 64'd1000, 64'd7, 1);
        issue(1, 3'd7, M7, 64'd1000, 64'd7, 1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
